// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its
// round-robin picker.
package fifo_arb_pkg;

  // Arbiter FSM: waiting for a requester, or one requester owns the port.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // The picker is written once for the largest supported requester count.
  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Width of a counter that must hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // First set bit of valid, searching ptr+1, ptr+2, ... modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [IDX_W-1:0]    ptr,
                                       input int                  nreq);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (k <= nreq && !res.found && valid[idx[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin picker: the requester after ptr_i with valid set.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int SEL_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             found_o
);

  rr_pick_t pick;

  // Widen to the picker's fixed size and narrow the chosen index back.
  always_comb begin
    pick    = rr_pick(MAX_NREQ'(valid_i), IDX_W'(ptr_i), NREQ);
    sel_o   = pick.idx[SEL_W-1:0];
    found_o = pick.found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ requesters.
// A grant lasts one burst, ended by last, BURST_MAX words or an idle timeout.
//
// Handshake: a requester word moves when req_valid[i] & req_ready[i] are both
// high at a wr_clk edge; that same cycle wr_en is high and din carries it.
// ready only goes high for the owner, and drops combinationally with full or
// wr_rst_busy, so the FIFO never sees a write it cannot take.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic               wr_clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               full,
  input  logic               wr_rst_busy,
  output logic               wr_en,
  output logic [DW-1:0]      din,
  output logic [NREQ-1:0]    grant,
  output logic               busy
);

  localparam int OWN_W  = $clog2(NREQ);
  localparam int WCNT_W = cnt_width(BURST_MAX);
  localparam int TCNT_W = cnt_width(TIMEOUT);

  arb_state_e        state_q;
  logic [NREQ-1:0]   grant_q;
  logic [OWN_W-1:0]  own_q;
  logic [OWN_W-1:0]  ptr_q;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [TCNT_W-1:0] to_cnt_q;

  logic             in_burst;
  logic             stall;
  logic             own_valid;
  logic             own_last;
  logic             xfer;
  logic             release_burst;
  logic [OWN_W-1:0] sel;
  logic             found;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .sel_o   (sel),
    .found_o (found)
  );

  // Owner's handshake and the three ways a burst can end.
  always_comb begin
    in_burst      = (state_q == BURST);
    stall         = full | wr_rst_busy;
    own_valid     = req_valid[own_q];
    own_last      = req_last[own_q];
    xfer          = in_burst & own_valid & ~stall;
    release_burst = in_burst &
                    ((xfer & (own_last | (word_cnt_q == WCNT_W'(BURST_MAX - 1)))) |
                     (~own_valid & (to_cnt_q == TCNT_W'(TIMEOUT - 1))));
  end

  // FIFO-facing outputs; grant_q is one-hot of own_q, so it doubles as the ready mask.
  always_comb begin
    wr_en     = xfer;
    req_ready = (in_burst && !stall) ? grant_q : '0;
    din       = in_burst ? req_data[own_q*DW +: DW] : '0;
    grant     = grant_q;
    busy      = in_burst;
  end

  // Arbiter FSM with grant, owner, counters and round-robin pointer.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      own_q      <= '0;
      ptr_q      <= OWN_W'(NREQ - 1);
      word_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!wr_rst_busy && found) begin
            state_q    <= BURST;
            grant_q    <= NREQ'(1) << sel;
            own_q      <= sel;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
          end
        end
        BURST: begin
          if (release_burst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= own_q;
          end else if (xfer) begin
            word_cnt_q <= word_cnt_q + WCNT_W'(1);
            to_cnt_q   <= '0;
          end else if (!own_valid) begin
            // Only a silent owner counts toward the timeout; stalls hold it.
            to_cnt_q <= to_cnt_q + TCNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table for a
// last-terminated burst plus hand-written multi-cycle sequences.
module tb_fifo_wr_arbiter;

  localparam int DW   = 8;
  localparam int NREQ = 4;

  logic               wr_clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               full;
  logic               wr_rst_busy;
  logic               wr_en;
  logic [DW-1:0]      din;
  logic [NREQ-1:0]    grant;
  logic               busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
    logic [DW-1:0]   d1;
    logic            exp_wr_en;
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   exp_din;
  } vec_t;

  vec_t tbl[7];

  fifo_wr_arbiter #(.DW(DW), .NREQ(NREQ), .BURST_MAX(16), .TIMEOUT(8)) dut (
    .wr_clk      (wr_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .wr_rst_busy (wr_rst_busy),
    .wr_en       (wr_en),
    .din         (din),
    .grant       (grant),
    .busy        (busy)
  );

  // Clock and global time limit
  always #5 wr_clk = ~wr_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "time limit");
  end

  // Driver and checking tasks
  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Holds rst for three edges; on return the block is in its first IDLE cycle.
  task automatic do_reset(input logic [NREQ-1:0] v, input logic wbusy, input bit check);
    rst         = 1'b1;
    req_valid   = v;
    req_last    = '0;
    full        = 1'b0;
    wr_rst_busy = wbusy;
    repeat (3) step();
    #1;
    if (check) begin
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_din",   32'(din), 0);
      chk("rst_busy",  32'(busy), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int n, total, k, k2, g, w, bad;
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] hist[14];

    // Last-terminated burst from requester 1, one row per cycle.
    tbl[0] = '{4'b0010, 4'b0000, 8'h10, 1'b0, 4'b0000, 4'b0000, 8'h00};
    tbl[1] = '{4'b0010, 4'b0000, 8'h10, 1'b1, 4'b0010, 4'b0010, 8'h10};
    tbl[2] = '{4'b0010, 4'b0000, 8'h11, 1'b1, 4'b0010, 4'b0010, 8'h11};
    tbl[3] = '{4'b0010, 4'b0000, 8'h12, 1'b1, 4'b0010, 4'b0010, 8'h12};
    tbl[4] = '{4'b0010, 4'b0000, 8'h13, 1'b1, 4'b0010, 4'b0010, 8'h13};
    tbl[5] = '{4'b0010, 4'b0010, 8'h14, 1'b1, 4'b0010, 4'b0010, 8'h14};
    tbl[6] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 4'b0000, 8'h00};

    req_data = '0;
    for (int i = 0; i < NREQ; i++) set_data(i, 8'(8'hA0 + i));

    // Reset with every requester valid, then first grant and first write.
    do_reset(4'b1111, 1'b0, 1'b1);
    #1;
    chk("t1_idle_grant", 32'(grant), 0);
    chk("t1_idle_wr_en", 32'(wr_en), 0);
    step(); #1;
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_din",   32'(din), 32'hA0);

    // Fairness: four continuous requesters, owners 0,1,2,3 then 0 again.
    for (int i = 0; i < NREQ; i++) set_data(i, 8'(8'h30 + i));
    do_reset(4'b1111, 1'b0, 1'b0);
    total = 0;
    for (int b = 0; b < NREQ; b++) begin
      oh = 4'(1) << b;
      n  = 0;
      repeat (16) begin
        step(); #1;
        if (grant == oh && wr_en && din == 8'(8'h30 + b)) n++;
        if (wr_en) total++;
      end
      chk($sformatf("t2_words_owner%0d", b), 32'(n), 16);
      step(); #1;
      chk($sformatf("t2_gap_owner%0d", b), {grant, 3'b000, wr_en}, 0);
    end
    step(); #1;
    chk("t2_regrant0", 32'(grant), 32'h1);
    chk("t2_total_writes", 32'(total), 64);

    // Table: last on the fifth word of requester 1.
    do_reset(4'b0000, 1'b0, 1'b0);
    for (int r = 0; r < 7; r++) begin
      step();
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      set_data(1, tbl[r].d1);
      #1;
      chk($sformatf("t3_wr_en_r%0d", r), 32'(wr_en), 32'(tbl[r].exp_wr_en));
      chk($sformatf("t3_grant_r%0d", r), 32'(grant), 32'(tbl[r].exp_grant));
      chk($sformatf("t3_ready_r%0d", r), 32'(req_ready), 32'(tbl[r].exp_ready));
      chk($sformatf("t3_din_r%0d", r),   32'(din), 32'(tbl[r].exp_din));
    end

    // Backpressure: full on burst cycles 3..6 of a requester-0 burst.
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    set_data(0, 8'h40);
    do_reset(4'b0001, 1'b0, 1'b0);
    k = 0; g = 0; w = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      full      = (c >= 3 && c <= 6);
      req_valid = (k < 16) ? 4'b0001 : 4'b0000;
      set_data(0, 8'(8'h40 + k));
      #1;
      if (grant == 4'b0001) g++;
      if (full && (wr_en || req_ready != 0)) bad++;
      if (wr_en) begin
        w++;
        if (exp_q.size() == 0) chk("t4_extra_write", 32'(din), 0);
        else chk("t4_din", 32'(din), 32'(exp_q.pop_front()));
      end
      if (req_valid[0] && req_ready[0]) k++;
      if (grant == 0 && c > 1) break;
    end
    full = 1'b0;
    chk("t4_stall_outputs", 32'(bad), 0);
    chk("t4_writes", 32'(w), 16);
    chk("t4_burst_cycles", 32'(g), 20);
    chk("t4_queue_left", 32'(exp_q.size()), 0);

    // Timeout: requester 2 sends three words then goes quiet; 3 waits.
    k2 = 0; g = 0; w = 0;
    set_data(2, 8'h50);
    set_data(3, 8'h60);
    do_reset(4'b1100, 1'b0, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      step();
      req_valid[2] = (k2 < 3);
      set_data(2, 8'(8'h50 + k2));
      #1;
      hist[c] = grant;
      if (grant == 4'b0100) begin
        g++;
        if (wr_en) w++;
      end
      if (req_valid[2] && req_ready[2]) k2++;
    end
    chk("t5_grant_cycles", 32'(g), 11);
    chk("t5_writes_req2", 32'(w), 3);
    chk("t5_idle_gap", 32'(hist[12]), 0);
    chk("t5_grant_req3", 32'(hist[13]), 32'h8);

    // wr_rst_busy after reset blocks arbitration; mid-burst it stalls only.
    set_data(0, 8'h70);
    do_reset(4'b0001, 1'b1, 1'b0);
    bad = 0;
    repeat (10) begin
      step(); #1;
      if (grant != 0 || wr_en) bad++;
    end
    chk("t6_no_grant_busy", 32'(bad), 0);
    step();
    wr_rst_busy = 1'b0;
    #1;
    chk("t6_grant_pending", 32'(grant), 0);
    g = 0; w = 0; bad = 0;
    // Two words, five silent cycles, a four-cycle stall during which the
    // requester offers a word, then it withdraws and the timeout finishes.
    for (int c = 1; c <= 15; c++) begin
      step();
      req_valid[0] = (c <= 2) || (c >= 8 && c <= 11);
      wr_rst_busy  = (c >= 8 && c <= 11);
      #1;
      if (c <= 14) begin
        if (grant == 4'b0001) g++;
      end else begin
        chk("t6_released", 32'(grant), 0);
      end
      if (wr_en) w++;
      if (wr_rst_busy && (wr_en || req_ready != 0)) bad++;
    end
    chk("t6_grant_cycles", 32'(g), 14);
    chk("t6_writes", 32'(w), 2);
    chk("t6_stall_outputs", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
